// File: rtl/bitstream_reader.sv
// bitstream_reader: MSB-first bit extraction from a packed 32-bit word stream.
// A 64-bit left-aligned shift buffer holds unread bits (bit 63 is the next
// bit). Fields of 1..32 bits are returned right-aligned, one cycle after
// acceptance. Flush drops bits up to the next byte boundary. An illegal
// request size latches a sticky error that blocks reads until sync_clr.
// Optional feature macro: BITSTREAM_READER_POS_EN enables the bit_pos counter;
// without it bit_pos is tied to zero.
module bitstream_reader (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        sync_clr,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        rd_req,
  input  logic [5:0]  rd_size,
  output logic        rd_ready,
  output logic        rd_valid,
  output logic [31:0] rd_val,
  input  logic        flush,
  output logic [6:0]  fill,
  output logic        err,
  output logic [31:0] bit_pos
);

  typedef enum logic {
    ST_OK  = 1'b0,
    ST_ERR = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] shift_buf;
  logic [63:0] buf_next;
  logic [6:0]  consumed;
  logic [6:0]  fill_after;
  logic [6:0]  fill_next;
  logic [31:0] rd_field;
  logic        rd_req_legal;
  logic        load;
  logic        rd_accept;

  assign rd_req_legal = (rd_size != 6'd0) && (rd_size <= 6'd32);
  assign err          = (state == ST_ERR);
  assign in_ready     = (fill <= 7'd32) && !sync_clr;
  assign rd_ready     = rd_req_legal && (fill >= {1'b0, rd_size}) &&
                        !flush && !sync_clr && !err;
  assign load         = in_valid && in_ready;
  assign rd_accept    = rd_req && rd_ready;

  // Top rd_size bits of the buffer, right-aligned; only used when legal.
  assign rd_field = shift_buf[63:32] >> (6'd32 - rd_size);

  // Bits consumed this cycle and the resulting buffer/fill after any load.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    consumed = 7'd0;
    if (flush) begin
      // Words are 32-bit aligned, so fill mod 8 is the distance to a byte edge.
      consumed = {4'd0, fill[2:0]};
    end else if (rd_accept) begin
      consumed = {1'b0, rd_size};
    end
    fill_after = fill - consumed;
    // Bits below the fill level are always zero, so the new word can be ORed
    // in directly behind the remaining unread bits.
    buf_next = shift_buf << consumed;
    if (load) begin
      buf_next = buf_next | ({in_data, 32'd0} >> fill_after);
    end
    fill_next = load ? (fill_after + 7'd32) : fill_after;
  end

  // Error FSM next state: sticky until sync_clr, which has top priority.
  always_comb begin
    state_next = state;
    if (sync_clr) begin
      state_next = ST_OK;
    end else if (rd_req && !rd_req_legal) begin
      state_next = ST_ERR;
    end
  end

  // Error FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_OK;
    end else begin
      state <= state_next;
    end
  end

  // Shift buffer and fill level; the buffer is reset because unread-bit
  // zeroing below the fill level is relied on by the load merge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_buf <= 64'd0;
      fill      <= 7'd0;
    end else if (sync_clr) begin
      shift_buf <= 64'd0;
      fill      <= 7'd0;
    end else begin
      shift_buf <= buf_next;
      fill      <= fill_next;
    end
  end

  // Read result: one-cycle valid pulse; the value holds until the next accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_val   <= 32'd0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        rd_val <= rd_field;
      end
    end
  end

`ifdef BITSTREAM_READER_POS_EN
  // Stream position: all consumed bits, flushed bits included; wraps at 2^32.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_pos <= 32'd0;
    end else if (sync_clr) begin
      bit_pos <= 32'd0;
    end else begin
      bit_pos <= bit_pos + {25'd0, consumed};
    end
  end
`else
  assign bit_pos = 32'd0;
`endif

endmodule

// File: tb/tb_bitstream_reader.sv
// Self-checking bench for bitstream_reader: directed scenarios followed by
// randomized traffic, compared every cycle against a bit-queue model.
module tb_bitstream_reader;

  logic        clock;
  logic        reset_n;
  logic        sync_clr;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        rd_req;
  logic [5:0]  rd_size;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_val;
  logic        flush;
  logic [6:0]  fill;
  logic        err;
  logic [31:0] bit_pos;

  bitstream_reader dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .sync_clr (sync_clr),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .rd_req   (rd_req),
    .rd_size  (rd_size),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_val   (rd_val),
    .flush    (flush),
    .fill     (fill),
    .err      (err),
    .bit_pos  (bit_pos)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the unread stream as a queue of bits, earliest first.
  bit          m_bits[$];
  int unsigned m_pos;
  bit          m_err;
  bit          m_rd_valid;
  logic [31:0] m_rd_val;

  // Combinational outputs observed just before the last edge.
  logic        seen_in_ready;
  logic        seen_rd_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_pos      = 0;
    m_err      = 1'b0;
    m_rd_valid = 1'b0;
    m_rd_val   = 32'd0;
  endtask

  function automatic logic [31:0] exp_pos();
`ifdef BITSTREAM_READER_POS_EN
    return m_pos;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_regs();
    check("fill", {25'd0, fill}, m_bits.size());
    check("err", {31'd0, err}, {31'd0, m_err});
    check("rd_valid", {31'd0, rd_valid}, {31'd0, m_rd_valid});
    check("rd_val", rd_val, m_rd_val);
    check("bit_pos", bit_pos, exp_pos());
  endtask

  // One clock cycle: drive inputs, check combinational handshakes, clock,
  // advance the model, check registered outputs. Entered/left at posedge+1.
  task automatic step(input bit v, input logic [31:0] d, input bit rq,
                      input logic [5:0] sz, input bit fl, input bit sc);
    bit          legal;
    bit          exp_in_ready;
    bit          exp_rd_ready;
    int          n;
    logic [31:0] val;
    in_valid = v;
    in_data  = d;
    rd_req   = rq;
    rd_size  = sz;
    flush    = fl;
    sync_clr = sc;
    #1;
    legal        = (sz != 0) && (sz <= 32);
    exp_in_ready = (m_bits.size() <= 32) && !sc;
    exp_rd_ready = legal && (m_bits.size() >= sz) && !fl && !sc && !m_err;
    seen_in_ready = in_ready;
    seen_rd_ready = rd_ready;
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_in_ready});
    check("rd_ready", {31'd0, rd_ready}, {31'd0, exp_rd_ready});
    @(posedge clock);
    #1;
    m_rd_valid = 1'b0;
    if (sc) begin
      m_bits.delete();
      m_pos = 0;
      m_err = 1'b0;
    end else begin
      if (fl) begin
        n = m_bits.size() % 8;
        for (int i = 0; i < n; i++) void'(m_bits.pop_front());
        m_pos += n;
      end else if (rq && exp_rd_ready) begin
        val = 32'd0;
        for (int i = 0; i < sz; i++) val = {val[30:0], m_bits.pop_front()};
        m_pos += sz;
        m_rd_valid = 1'b1;
        m_rd_val   = val;
      end
      if (rq && !legal) m_err = 1'b1;
      if (v && exp_in_ready) begin
        for (int i = 31; i >= 0; i--) m_bits.push_back(d[i]);
      end
    end
    check_regs();
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({pfx, "_rd_ready"}, {31'd0, rd_ready}, 32'd0);
    check({pfx, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
    check({pfx, "_rd_val"}, rd_val, 32'd0);
    check({pfx, "_fill"}, {25'd0, fill}, 32'd0);
    check({pfx, "_err"}, {31'd0, err}, 32'd0);
    check({pfx, "_bit_pos"}, bit_pos, 32'd0);
  endtask

  int accepted;

  initial begin
    reset_n  = 1'b0;
    sync_clr = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'd0;
    rd_req   = 1'b0;
    rd_size  = 6'd0;
    flush    = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("rst");
    #10 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Basic extraction.
    step(1'b1, 32'hA5C30F81, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 6'd4, 1'b0, 1'b0);
    check("basic_rd4", rd_val, 32'hA);
    step(1'b0, 32'd0, 1'b1, 6'd8, 1'b0, 1'b0);
    check("basic_rd8", rd_val, 32'h5C);
    step(1'b0, 32'd0, 1'b1, 6'd3, 1'b0, 1'b0);
    check("basic_rd3", rd_val, 32'h1);
    check("basic_fill", {25'd0, fill}, 32'd17);

    // Flush alignment; a same-cycle request is blocked.
    step(1'b0, 32'd0, 1'b1, 6'd8, 1'b1, 1'b0);
    check("flush_fill", {25'd0, fill}, 32'd16);
    check("flush_blocks_rd", {31'd0, seen_rd_ready}, 32'd0);
    step(1'b0, 32'd0, 1'b1, 6'd8, 1'b0, 1'b0);
    check("flush_rd8", rd_val, 32'h0F);
    step(1'b0, 32'd0, 1'b0, 6'd0, 1'b1, 1'b0);
    check("flush_aligned_fill", {25'd0, fill}, 32'd8);

    // Word straddle with a stall.
    step(1'b0, 32'd0, 1'b0, 6'd0, 1'b0, 1'b1);
    step(1'b1, 32'h12345678, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b1, 32'h9ABCDEF0, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 6'd28, 1'b0, 1'b0);
    check("straddle_rd28", rd_val, 32'h1234567);
    step(1'b0, 32'd0, 1'b1, 6'd8, 1'b0, 1'b0);
    check("straddle_rd8", rd_val, 32'h89);
    step(1'b0, 32'd0, 1'b1, 6'd32, 1'b0, 1'b0);
    check("straddle_stall", {31'd0, seen_rd_ready}, 32'd0);
    check("straddle_stall_fill", {25'd0, fill}, 32'd28);
    step(1'b1, 32'h3C000000, 1'b1, 6'd32, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 6'd32, 1'b0, 1'b0);
    check("straddle_rd32", rd_val, 32'hABCDEF03);

    // Backpressure.
    step(1'b0, 32'd0, 1'b0, 6'd0, 1'b0, 1'b1);
    accepted = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, $urandom(), 1'b0, 6'd0, 1'b0, 1'b0);
      if (seen_in_ready) accepted++;
    end
    check("bp_accepted", accepted, 32'd2);
    check("bp_fill", {25'd0, fill}, 32'd64);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);

    // Illegal size: sticky error, then cleared by sync_clr.
    step(1'b0, 32'd0, 1'b1, 6'd0, 1'b0, 1'b0);
    check("ill_err", {31'd0, err}, 32'd1);
    step(1'b0, 32'd0, 1'b1, 6'd8, 1'b0, 1'b0);
    check("ill_refused", {31'd0, seen_rd_ready}, 32'd0);
    step(1'b0, 32'd0, 1'b0, 6'd0, 1'b0, 1'b1);
    check("ill_clr_err", {31'd0, err}, 32'd0);
    check("ill_clr_fill", {25'd0, fill}, 32'd0);

    // Async reset while a read result is showing.
    step(1'b1, 32'hDEADBEEF, 1'b0, 6'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 6'd16, 1'b0, 1'b0);
    in_valid = 1'b0;
    rd_req   = 1'b0;
    check("arst_pre_valid", {31'd0, rd_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    model_reset();
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_regs();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit          v;
      bit          rq;
      bit          fl;
      bit          sc;
      logic [5:0]  sz;
      v  = ($urandom_range(0, 99) < 55);
      rq = ($urandom_range(0, 99) < 65);
      fl = ($urandom_range(0, 19) == 0);
      sc = m_err ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 59) == 0) begin
        sz = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(33, 63));
      end else begin
        sz = 6'($urandom_range(1, 32));
      end
      step(v, $urandom(), rq, sz, fl, sc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bitstream_reader.md
# bitstream_reader

Decoder-side bit extraction front end for the ProRes datapath. It accepts the packed, MSB-first 32-bit word stream that the encoder's bit-writer produces and returns fields of 1–32 bits on request. This is the consumer end of the `enable`/`val`/`size_of_bit`/`flush` bit-writer protocol. It sits between slice memory and the future DC/AC VLC decoders and header parsers. It provides byte re-alignment, the counterpart of the writer's flush.

## Interface
Parameters:
- none

Ports:
- `clock`  in  1  — single clock; all state updates on the rising edge.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `sync_clr`  in  1  — synchronous clear at a slice boundary; empties the buffer, zeroes the position, clears `err`.
- `in_valid`  in  1  — `in_data` holds the next stream word.
- `in_data`  in  32  — stream word; bit 31 is the earliest bit in the stream.
- `in_ready`  out  1  — word accepted on the edge where `in_valid & in_ready`.
- `rd_req`  in  1  — request `rd_size` bits.
- `rd_size`  in  6  — field width; legal range 1..32.
- `rd_ready`  out  1  — combinational; the request is consumed on the edge where `rd_req & rd_ready`.
- `rd_valid`  out  1  — one-cycle pulse carrying the result of an accepted request.
- `rd_val`  out  32  — extracted field, right-aligned, zero-extended.
- `flush`  in  1  — discard bits up to the next byte boundary.
- `fill`  out  7  — number of buffered bits, 0..64.
- `err`  out  1  — sticky illegal-request flag.
- `bit_pos`  out  32  — total bits consumed, including flushed bits (see Configuration).

## Operation
- **Storage:**
  - 64-bit left-aligned shift buffer `buf`; bit 63 is the next unread bit.
  - 7-bit counter `fill`.
- **Load:**
  - `in_ready = (fill <= 32) & !sync_clr`.
  - An accepted word is written to `buf[63-fill' -: 32]`, where `fill'` is `fill` after this cycle's consume.
  - A load can always coexist with a consume.
- **Read:**
  - `rd_ready = rd_req_legal & (fill >= rd_size) & !flush & !sync_clr & !err`, where `rd_req_legal = (rd_size != 0) & (rd_size <= 32)`.
  - On accept:
    - `rd_val <= buf[63 -: rd_size]` right-aligned.
    - `buf <<= rd_size`.
    - `fill -= rd_size`.
  - If `rd_req` is held while `fill < rd_size`, the reader stalls; no state changes.
- **Flush:**
  - Discards `fill[2:0]` bits.
  - Words are 32-bit aligned, so `fill mod 8` always equals the distance to the next stream byte boundary.
  - Flush while already aligned discards nothing.
  - Flush blocks a same-cycle `rd_req`; the request is accepted on a later cycle.
- **Error state machine:**
  - States are OK and ERR.
  - OK → ERR when `rd_req & !rd_req_legal`.
  - ERR blocks all reads; loads continue.
  - ERR → OK only on reset or `sync_clr`.
  - `err = (state == ERR)`.
- **Arithmetic:**
  - `fill` next = `fill - consumed + (load ? 32 : 0)`. It never exceeds 64 and never underflows.
  - `bit_pos` wraps modulo 2^32.
- **Priority in one cycle:** `sync_clr` > flush > read. A load is independent of these except under `sync_clr`, where the word is not accepted.

## Timing
- **Reset values:**
  - `in_ready` = 1 (combinational from `fill` = 0)
  - `rd_ready` = 0
  - `rd_valid` = 0
  - `rd_val` = 0
  - `fill` = 0
  - `err` = 0
  - `bit_pos` = 0
  - `buf` = 0
- **Read latency:** `rd_valid`/`rd_val` appear exactly 1 cycle after the accepting edge. `rd_val` holds its value until the next accept.
- **Throughput:** back-to-back requests of up to 32 bits each cycle are accepted, provided `in_valid` keeps the buffer at ≥ 32 bits.
- **Load turnaround:** a word loaded on edge N is readable on edge N+1.
- **Reset mid-operation:** asserting `reset_n` low clears all state immediately. An outstanding `rd_valid` pulse is dropped.

## Configuration
- **`BITSTREAM_READER_POS_EN` defined:**
  - `bit_pos` counts consumed bits.
  - Reads add `rd_size`; flush adds `fill[2:0]`.
  - `bit_pos` is cleared by reset and by `sync_clr`.
- **Not defined:**
  - `bit_pos` is tied to 0.
  - No counter logic is synthesized.
  - All other behaviour is identical.

## Test plan
- **Basic extraction:** load `0xA5C30F81`; read 4, 8, 3 → `rd_val` = `0xA`, `0x5C`, `0x1`; `fill` = 17; `bit_pos` = 15 with POS_EN.
- **Flush alignment:** from the previous state, flush → 1 bit dropped (`fill` = 16); read 8 → `0x0F`; `bit_pos` = 24.
- **Word straddle:** load `0x12345678` then `0x9ABCDEF0`; read 28 → `0x1234567`; read 8 → `0x89`; read 32 → `0xABCDEF0` with `fill` = 28 short, so the reader stalls with `rd_ready` = 0 until a third word arrives.
- **Backpressure:** hold `in_valid` = 1 with no reads → exactly 2 words accepted; then `in_ready` = 0 and `fill` = 64.
- **Illegal size:** `rd_req` with `rd_size` = 0 → `err` = 1 next cycle; later legal reads are refused; `sync_clr` → `err` = 0, `fill` = 0.
- **Async reset:** pulse `reset_n` low while `rd_valid` is due → all outputs return to reset values without a clock edge.
